// File: rtl/palette_fade_lut.sv
// ============================================================================
// Module      : palette_fade_lut
// Description : Programmable multi-bank colour palette with per-frame
//               brightness fade. Maps a pixel index to 4:4:4 RGB through a
//               writable table of NUM_PAL banks. The active bank changes only
//               on frame_start. A fade engine scales all colours by a level
//               that steps once per frame_start.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   pixel clock
//   reset          in   asynchronous, active-high
//   pix_valid_in   in   pix_idx valid this cycle
//   pix_idx        in   colour index to look up
//   pal_sel        in   requested bank, sampled only on frame_start
//   frame_start    in   one-cycle pulse at start of vertical blank
//   wr_en          in   table write strobe
//   wr_pal/wr_idx  in   bank / entry to write
//   wr_rgb         in   {r,g,b} to write
//   fade_cmd       in   00 none, 01 fade out, 10 fade in, 11 none
//   transparent    out  looked-up index == TRANSP_IDX (optional)
//   fade_busy      out  fade in progress
//   pix_valid_out  out  red/green/blue valid (2 cycles after pix_valid_in)
//   red/green/blue out  scaled colour
// Configuration
//   PALETTE_TRANSPARENT_EN : adds parameter TRANSP_IDX and output transparent
// ============================================================================
`default_nettype none

module palette_fade_lut #(
    parameter int IDX_W      = 4,
    parameter int NUM_PAL    = 4,
    parameter int CH_W       = 4,
    parameter int LVL_W      = 4,
    parameter int STEP       = 4,
`ifdef PALETTE_TRANSPARENT_EN
    parameter int TRANSP_IDX = 0,
`endif
    localparam int PAL_W     = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_valid_in,
    input  logic [IDX_W-1:0]    pix_idx,
    input  logic [PAL_W-1:0]    pal_sel,
    input  logic                frame_start,
    input  logic                wr_en,
    input  logic [PAL_W-1:0]    wr_pal,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [3*CH_W-1:0]   wr_rgb,
    input  logic [1:0]          fade_cmd,
`ifdef PALETTE_TRANSPARENT_EN
    output logic                transparent,
`endif
    output logic                fade_busy,
    output logic                pix_valid_out,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue
);

    localparam int RGB_W  = 3 * CH_W;
    localparam int ADDR_W = PAL_W + IDX_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int PROD_W = CH_W + LVL_W + 1;

    localparam logic [LVL_W:0] FULL_LVL = (LVL_W + 1)'(2 ** LVL_W);
    localparam logic [LVL_W:0] STEP_LVL = (LVL_W + 1)'(STEP);

    // ------------------------------------------------------------------
    // Palette table. Contents are not touched by reset; they power up zero.
    // ------------------------------------------------------------------
    logic [RGB_W-1:0] pal_mem [DEPTH] = '{default: '0};
    logic [RGB_W-1:0] rd_rgb;
    logic [PAL_W-1:0] active_bank;

    // Read and write share one process so a same-address collision returns
    // the entry as it was before this cycle's write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pal_mem[{wr_pal, wr_idx}] <= wr_rgb;
        end
        rd_rgb <= pal_mem[{active_bank, pix_idx}];
    end

    // Bank select: lookups in the frame_start cycle still see the old bank
    // because the read above samples active_bank before this update lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_bank <= '0;
        end else if (frame_start && (int'(pal_sel) < NUM_PAL)) begin
            active_bank <= pal_sel;
        end
    end

    // ------------------------------------------------------------------
    // Fade engine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_t;

    fade_state_t      state, state_next;
    logic [LVL_W:0]   lvl, lvl_next;
    logic [LVL_W:0]   lvl_dn;
    logic [LVL_W+1:0] lvl_sum;
    logic [LVL_W:0]   lvl_up;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lvl   <= FULL_LVL;
        end else begin
            state <= state_next;
            lvl   <= lvl_next;
        end
    end

    always_comb begin
        state_next = state;
        lvl_next   = lvl;
        fade_busy  = 1'b0;

        // Saturating step in each direction.
        lvl_dn  = (lvl > STEP_LVL) ? (lvl - STEP_LVL) : '0;
        lvl_sum = {1'b0, lvl} + {1'b0, STEP_LVL};
        lvl_up  = (lvl_sum >= {1'b0, FULL_LVL}) ? FULL_LVL : lvl_sum[LVL_W:0];

        case (state)
            IDLE: begin
                if (fade_cmd == 2'b01) begin
                    state_next = FADE_OUT;
                end else if (fade_cmd == 2'b10) begin
                    state_next = FADE_IN;
                end
            end
            FADE_OUT: begin
                fade_busy = 1'b1;
                if (frame_start) begin
                    lvl_next = lvl_dn;
                    if (lvl_dn == '0) begin
                        state_next = IDLE;
                    end
                end
            end
            FADE_IN: begin
                fade_busy = 1'b1;
                if (frame_start) begin
                    lvl_next = lvl_up;
                    if (lvl_up == FULL_LVL) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output pipeline
    // ------------------------------------------------------------------
    // (ch * lvl) >> LVL_W, truncating; lvl == FULL reproduces ch exactly.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0]  ch,
                                                 input logic [LVL_W:0]   l);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(ch) * PROD_W'(l);
        return CH_W'(prod >> LVL_W);
    endfunction

    logic valid_s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_s1 <= 1'b0;
        end else begin
            valid_s1 <= pix_valid_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid_out <= 1'b0;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
        end else begin
            pix_valid_out <= valid_s1;
            // Colour holds its last value while no pixel is flowing.
            if (valid_s1) begin
                red   <= scale_ch(rd_rgb[3*CH_W-1:2*CH_W], lvl);
                green <= scale_ch(rd_rgb[2*CH_W-1:CH_W],   lvl);
                blue  <= scale_ch(rd_rgb[CH_W-1:0],        lvl);
            end
        end
    end

`ifdef PALETTE_TRANSPARENT_EN
    // Transparency depends only on the raw index, not bank or brightness.
    logic [IDX_W-1:0] idx_s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_s1      <= '0;
            transparent <= 1'b0;
        end else begin
            idx_s1      <= pix_idx;
            transparent <= valid_s1 && (idx_s1 == IDX_W'(TRANSP_IDX));
        end
    end
`endif

endmodule

`default_nettype wire
